// File: rtl/mem_arbiter.sv
// Two-core arbiter onto a single shared memory with separate read and write ports.
// Round-robin arbitration on each port; read returns are routed back by a latency-matched tag pipe.
module mem_arbiter #(
  parameter int RD_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        c0_ren,
  input  logic [14:0] c0_raddr,
  output logic        c0_rgnt,
  output logic        c0_rvalid,
  output logic [15:0] c0_rdata,
  input  logic        c0_wen,
  input  logic [14:0] c0_waddr,
  input  logic [15:0] c0_wdata,
  output logic        c0_wgnt,
  input  logic        c1_ren,
  input  logic [14:0] c1_raddr,
  output logic        c1_rgnt,
  output logic        c1_rvalid,
  output logic [15:0] c1_rdata,
  input  logic        c1_wen,
  input  logic [14:0] c1_waddr,
  input  logic [15:0] c1_wdata,
  output logic        c1_wgnt,
  output logic [14:0] m_raddr,
  input  logic [15:0] m_rdata,
  output logic        m_wen,
  output logic [14:0] m_waddr,
  output logic [15:0] m_wdata
);

  typedef struct packed {
    logic vld;
    logic core;
  } tag_t;

  logic                    rptr_q, rptr_d;
  logic                    wptr_q, wptr_d;
  logic [14:0]             raddr_q, raddr_d;
  logic [15:0]             c0_rdata_q, c0_rdata_d;
  logic [15:0]             c1_rdata_q, c1_rdata_d;
  tag_t [RD_LAT-1:0]       tag_q, tag_d;

  logic        r_any, w_any, r_win, w_win, r_hit, r_go;
  logic [14:0] r_addr;

  // Arbitration: grants are suppressed while reset is held.
  always_comb begin
    r_any   = rst_n & (c0_ren | c1_ren);
    w_any   = rst_n & (c0_wen | c1_wen);
    r_win   = (c0_ren & c1_ren) ? rptr_q : c1_ren;
    w_win   = (c0_wen & c1_wen) ? wptr_q : c1_wen;
    r_addr  = r_win ? c1_raddr : c0_raddr;
    m_waddr = w_win ? c1_waddr : c0_waddr;
    m_wdata = w_win ? c1_wdata : c0_wdata;
    m_wen   = w_any;
    // A read colliding with this cycle's write waits so it observes the new data.
    r_hit   = w_any & (r_addr == m_waddr);
    r_go    = r_any & ~r_hit;
    c0_wgnt = w_any & ~w_win;
    c1_wgnt = w_any & w_win;
    c0_rgnt = r_go & ~r_win;
    c1_rgnt = r_go & r_win;
    m_raddr = r_go ? r_addr : raddr_q;
  end

  always_comb begin
    raddr_d  = m_raddr;
    rptr_d   = r_go ? ~r_win : rptr_q;
    wptr_d   = w_any ? ~w_win : wptr_q;
    tag_d    = tag_q;
    tag_d[0] = '{vld: r_go, core: r_win};
    for (int i = 1; i < RD_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // Return routing from the oldest tag; rdata holds between returns.
  always_comb begin
    c0_rvalid  = tag_q[RD_LAT-1].vld & ~tag_q[RD_LAT-1].core;
    c1_rvalid  = tag_q[RD_LAT-1].vld & tag_q[RD_LAT-1].core;
    c0_rdata   = c0_rvalid ? m_rdata : c0_rdata_q;
    c1_rdata   = c1_rvalid ? m_rdata : c1_rdata_q;
    c0_rdata_d = c0_rdata;
    c1_rdata_d = c1_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr_q     <= 1'b0;
      wptr_q     <= 1'b0;
      raddr_q    <= '0;
      c0_rdata_q <= '0;
      c1_rdata_q <= '0;
      tag_q      <= '0;
    end else begin
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      raddr_q    <= raddr_d;
      c0_rdata_q <= c0_rdata_d;
      c1_rdata_q <= c1_rdata_d;
      tag_q      <= tag_d;
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter RD_LAT, default 2: fixed read latency of the shared memory data port, in cycles from address to data; legal range 1..4.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 cN_ren  in  1  read request from core N (N = 0,1); held until granted.
REQ-005 cN_raddr  in  15  read halfword address [15:1] from core N.
REQ-006 cN_rgnt  out  1  read grant to core N, same cycle as the request (combinational).
REQ-007 cN_rvalid  out  1  one-cycle pulse: cN_rdata valid for core N's granted read.
REQ-008 cN_rdata  out  16  read data returned to core N.
REQ-009 cN_wen  in  1  write request from core N; held until granted.
REQ-010 cN_waddr  in  15  write halfword address from core N.
REQ-011 cN_wdata  in  16  write data from core N.
REQ-012 cN_wgnt  out  1  write grant to core N (combinational); write is complete at the end of the grant cycle.
REQ-013 m_raddr  out  15  address to the memory data read port.
REQ-014 m_rdata  in  16  memory read data, valid RD_LAT cycles after m_raddr.
REQ-015 m_wen  out  1  memory write enable.
REQ-016 m_waddr  out  15  memory write address.
REQ-017 m_wdata  out  16  memory write data.

Function
REQ-018 The read port and the write port SHALL be arbitrated independently; at most one read and one write are granted per cycle.
REQ-019 Each port SHALL use a 1-bit round-robin pointer: the core it names wins when both request; after any grant, the pointer SHALL point to the other core.
REQ-020 A single requesting core SHALL be granted in that cycle regardless of the pointer.
REQ-021 On a write grant, m_wen=1 and m_waddr/m_wdata SHALL equal the winner's inputs; with no write grant, m_wen=0.
REQ-022 On a read grant, m_raddr SHALL equal the winner's address; with no read grant, m_raddr SHALL hold its last value.
REQ-023 Hazard: if the read winner's address equals the write winner's address in the same cycle, the read SHALL NOT be granted that cycle, and the read pointer SHALL NOT change.
REQ-024 Each read grant SHALL push {valid=1, core id} into an RD_LAT-deep tag shift register; cycles without a read grant push valid=0.
REQ-025 When the tag at the output stage is valid, the arbiter SHALL pulse cN_rvalid for the tagged core only and drive cN_rdata = m_rdata; otherwise both rvalid=0.
REQ-026 cN_rdata SHALL hold its last returned value while cN_rvalid=0.
REQ-027 Read throughput SHALL be one grant per cycle with no bubbles; rdata order SHALL equal grant order.
REQ-028 Requests deasserted before grant SHALL be dropped without side effects.

Reset
REQ-029 While rst_n=0: both pointers = core 0, tag register cleared, all cN_rvalid=0, cN_rdata=0, m_raddr=0, m_wen=0; grants forced to 0.
REQ-030 Reads in flight when reset asserts SHALL be discarded; no rvalid SHALL follow for them after rst_n releases.
REQ-031 First grant after reset SHALL follow REQ-019 with pointer = core 0.

Verification
REQ-032 Contention: after reset, c0_ren and c1_ren both 1 for 4 cycles (addrs 0x10, 0x20) -> rgnt alternates c0,c1,c0,c1; m_raddr 0x10,0x20,0x10,0x20; rvalid pattern identical, delayed 2 cycles (RD_LAT=2).
REQ-033 Return routing: memory model returns 0xBEEF for addr 0x10, 0x1234 for 0x20 -> c0_rdata=0xBEEF with c0_rvalid, c1_rdata=0x1234 with c1_rvalid, never crossed.
REQ-034 Hazard: c0_wen addr 0x40 data 0x5555 and c1_ren addr 0x40 same cycle -> c0_wgnt=1, c1_rgnt=0; next cycle c1_rgnt=1; c1_rdata=0x5555 two cycles later.
REQ-035 Write contention: both cores write addr 0x80 (c0 0x1111, c1 0x2222) -> c0 granted first, c1 next cycle; memory holds 0x2222.
REQ-036 Reset mid-flight: read granted, rst_n low for 1 cycle before data returns -> no rvalid afterward; all outputs at REQ-029 values during reset.
REQ-037 Parameter sweep RD_LAT=1 and 4 -> rvalid exactly RD_LAT cycles after each grant, back-to-back reads stall-free.
